multi_reaction_timer: RTL and testbench
=======================================

# multi_reaction_timer

Parametrised multi-player reaction timer: after a start press it waits a pseudo-random number of millisecond ticks, lights the GO LED, then measures each player's reaction time in ms. Players who press early are flagged as fouls. The block also reports the round winner and a timeout. It sits between the button debouncers and the seven-segment display driver, in a single clock domain.

## Interface
Parameters:
- N_PLAYERS, 4: number of players / stop inputs (1..8)
- CNT_W, 11: width of the reaction counter and of each captured time
- DELAY_MIN, 1000: minimum random wait in ticks (must be >= 1)
- DELAY_SPAN_W, 11: random wait = DELAY_MIN + lfsr[DELAY_SPAN_W-1:0] ticks (DELAY_SPAN_W <= 16)
- LFSR_SEED, 16'hACE1: non-zero LFSR reset value

Ports:
- clk  in  1  system clock (50 MHz); single clock domain
- clear  in  1  reset, asynchronous, active-high
- tick  in  1  one-clk-wide 1 ms enable pulse, synchronous to clk
- start  in  1  debounced start level
- stop  in  N_PLAYERS  debounced per-player stop levels
- led  out  1  GO indicator
- state  out  2  IDLE=0, ARMED=1, GO=2, DONE=3
- times  out  N_PLAYERS*CNT_W  packed captured times; player i occupies [i*CNT_W +: CNT_W]
- valid  out  N_PLAYERS  player i has a legal time
- foul  out  N_PLAYERS  player i pressed before GO
- winner  out  N_PLAYERS  one-hot index of the fastest legal player
- timeout  out  1  counter saturated with at least one player unresolved

## Operation
- Edge detect: registered start_q and stop_q reset to all ones, so a button already held when reset releases produces no edge. Rising edge = input & ~q, evaluated combinationally and acted on at the same clk edge.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every clk in every state and reloads LFSR_SEED on reset.
- A player is resolved once its valid or foul bit is set. Further stop edges from a resolved player are ignored.
- IDLE: led=0.
  - start edge -> ARMED.
  - On that transition: load delay_cnt = DELAY_MIN + lfsr[DELAY_SPAN_W-1:0], and clear cnt, times, valid, foul, winner and timeout.
- ARMED: led=0.
  - On each tick, if delay_cnt==1 go to GO, else decrement delay_cnt.
  - A stop edge from player i sets foul[i].
  - If every player is foul after this cycle's updates -> DONE; this overrides a same-cycle move to GO.
- GO: led=1.
  - On each tick, cnt increments, saturating at 2^CNT_W-1.
  - A stop edge from unresolved player i sets times[i] = cnt (the pre-increment value when it coincides with a tick) and valid[i]=1.
  - winner is set by the first cycle with any capture. Within that cycle the lowest index wins. winner never changes afterwards in the round.
  - All players resolved -> DONE.
  - Otherwise, on the tick that makes cnt reach 2^CNT_W-1: set timeout=1 and go to DONE. Unresolved players keep valid=0 and foul=0.
- DONE: led=0; all results hold.
  - start edge -> ARMED, starting a new round with the same clearing as from IDLE.
- A start edge in ARMED or GO is ignored.
- Width rules: delay_cnt is max(DELAY_SPAN_W+1, clog2(DELAY_MIN+2^DELAY_SPAN_W)) bits. cnt is CNT_W bits and never wraps.

## Timing
- Reset (clear=1, asynchronous): state=IDLE, led=0, times=0, valid=0, foul=0, winner=0, timeout=0, cnt=0, delay_cnt=0, lfsr=LFSR_SEED, start_q and stop_q all ones. Asserting clear mid-round aborts it immediately.
- All outputs are registered and change only on a clk edge (or on clear).
- led and state update at the same edge.
- start is sampled high with start_q=0 at edge e -> state=ARMED after edge e.
- A stop edge sampled at edge e updates valid, foul, times and winner after edge e.
- Wait in ARMED is exactly DELAY_MIN + rnd ticks; led rises at the edge where the last of those ticks is sampled.
- Reaction time resolution is 1 tick. A press before the first GO tick reads 0.

## Test plan
Bench parameters: N_PLAYERS=2, CNT_W=4, DELAY_MIN=3, DELAY_SPAN_W=2; tick every 4 clk.
- Reset and seed: hold clear, then release with start=1 held -> no ARMED entry and all outputs 0. Drop start and raise it -> ARMED; led rises after 3 + (LFSR_SEED-derived lfsr[1:0] at that edge) ticks.
- Legal race: in GO, player1 presses after 5 ticks and player0 after 7 -> times={7,5}, valid=2'b11, winner=2'b10, DONE, led=0.
- Tie and tick coincidence: both players press on the same clk as the 4th tick -> times={3,3}, winner=2'b01.
- Foul: player0 presses in ARMED -> foul=2'b01. In GO, player1 presses at tick 2 -> valid=2'b10, winner=2'b10, DONE. Both players fouling in ARMED -> DONE without GO and led never rises.
- Timeout: nobody presses in GO -> after 15 ticks cnt=15, timeout=1, valid=0, DONE. With player0 pressing at tick 4 and player1 never pressing -> timeout=1, valid=2'b01.
- Abort and restart: clear pulse mid-GO -> IDLE with all outputs 0 immediately. A start edge in DONE -> ARMED with results cleared.

Source files
------------

// File: rtl/multi_reaction_timer.sv
// Multi-player reaction timer: random ARMED wait, GO LED, per-player ms capture, fouls, winner, timeout.
// Latency: all outputs registered, updated at the edge that samples the input event; no backpressure (level inputs).
module multi_reaction_timer #(
    parameter int          N_PLAYERS    = 4,
    parameter int          CNT_W        = 11,
    parameter int          DELAY_MIN    = 1000,
    parameter int          DELAY_SPAN_W = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       tick,
    input  logic                       start,
    input  logic [N_PLAYERS-1:0]       stop,
    output logic                       led,
    output logic [1:0]                 state,
    output logic [N_PLAYERS*CNT_W-1:0] times,
    output logic [N_PLAYERS-1:0]       valid,
    output logic [N_PLAYERS-1:0]       foul,
    output logic [N_PLAYERS-1:0]       winner,
    output logic                       timeout
);

    localparam int DLY_A = DELAY_SPAN_W + 1;
    localparam int DLY_B = $clog2(DELAY_MIN + (1 << DELAY_SPAN_W));
    localparam int DLY_W = (DLY_A > DLY_B) ? DLY_A : DLY_B;

    localparam logic [DLY_W-1:0] DLY_BASE = DLY_W'(DELAY_MIN);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        GO    = 2'd2,
        DONE  = 2'd3
    } st_t;

    st_t                  st;
    logic                 start_q;
    logic [N_PLAYERS-1:0] stop_q;
    logic [15:0]          lfsr;
    logic [15:0]          lfsr_nxt;
    logic [DLY_W-1:0]     delay_cnt;
    logic [DLY_W-1:0]     delay_load;
    logic [CNT_W-1:0]     cnt;

    logic                 start_rise;
    logic [N_PLAYERS-1:0] stop_rise;
    logic [N_PLAYERS-1:0] resolved;
    logic [N_PLAYERS-1:0] fresh;
    logic [N_PLAYERS-1:0] foul_nxt;
    logic [N_PLAYERS-1:0] resolved_nxt;
    logic [N_PLAYERS-1:0] first_cap;
    logic                 cnt_hits_max;

    assign state = st;

    // Right-shift Galois form of x^16+x^14+x^13+x^11.
    assign lfsr_nxt   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    assign delay_load = DLY_BASE + {{(DLY_W-DELAY_SPAN_W){1'b0}}, lfsr[DELAY_SPAN_W-1:0]};

    assign start_rise   = start & ~start_q;
    assign stop_rise    = stop & ~stop_q;
    assign resolved     = valid | foul;
    assign fresh        = stop_rise & ~resolved;
    assign foul_nxt     = foul | fresh;
    assign resolved_nxt = resolved | fresh;
    assign cnt_hits_max = tick && (cnt == CNT_MAX - 1'b1);

    // Lowest-indexed fresh press wins a same-cycle tie.
    always_comb begin
        first_cap = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (fresh[i]) begin
                first_cap    = '0;
                first_cap[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            st        <= IDLE;
            led       <= 1'b0;
            start_q   <= 1'b1;
            stop_q    <= '1;
            lfsr      <= LFSR_SEED;
            delay_cnt <= '0;
            cnt       <= '0;
            times     <= '0;
            valid     <= '0;
            foul      <= '0;
            winner    <= '0;
            timeout   <= 1'b0;
        end else begin
            lfsr    <= lfsr_nxt;
            start_q <= start;
            stop_q  <= stop;

            case (st)
                IDLE, DONE: begin
                    if (start_rise) begin
                        st        <= ARMED;
                        led       <= 1'b0;
                        delay_cnt <= delay_load;
                        cnt       <= '0;
                        times     <= '0;
                        valid     <= '0;
                        foul      <= '0;
                        winner    <= '0;
                        timeout   <= 1'b0;
                    end
                end

                ARMED: begin
                    foul <= foul_nxt;
                    // A full foul-out ends the round even if GO was due this cycle.
                    if (&foul_nxt) begin
                        st  <= DONE;
                        led <= 1'b0;
                    end else if (tick) begin
                        if (delay_cnt == DLY_ONE) begin
                            st  <= GO;
                            led <= 1'b1;
                        end else begin
                            delay_cnt <= delay_cnt - 1'b1;
                        end
                    end
                end

                GO: begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (fresh[i]) begin
                            times[i*CNT_W +: CNT_W] <= cnt;
                        end
                    end
                    valid <= valid | fresh;
                    if ((winner == '0) && (|fresh)) begin
                        winner <= first_cap;
                    end
                    if (tick && (cnt != CNT_MAX)) begin
                        cnt <= cnt + 1'b1;
                    end

                    if (&resolved_nxt) begin
                        st  <= DONE;
                        led <= 1'b0;
                    end else if (cnt_hits_max) begin
                        timeout <= 1'b1;
                        st      <= DONE;
                        led     <= 1'b0;
                    end
                end

                default: begin
                    st  <= IDLE;
                    led <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_reaction_timer.sv
// Scoreboard bench for multi_reaction_timer: 2 players, 4-bit counter, 3..6 tick random wait, tick every 4 clk.
module tb_multi_reaction_timer;

    typedef struct packed {
        logic [7:0] times;
        logic [1:0] valid;
        logic [1:0] foul;
        logic [1:0] winner;
        logic       timeout;
    } res_t;

    logic       clk = 1'b0;
    logic       clear;
    logic       tick;
    logic       start;
    logic [1:0] stop;
    logic       led;
    logic [1:0] state;
    logic [7:0] times;
    logic [1:0] valid;
    logic [1:0] foul;
    logic [1:0] winner;
    logic       timeout;

    int         n_vec = 0;
    int         n_err = 0;
    int         phase = 0;
    int         exp_delay = 0;
    int         go_ticks = 0;
    logic       last_tick = 1'b0;
    logic       start_lvl = 1'b0;
    logic       led_seen = 1'b0;
    logic [1:0] prev_state = 2'd0;
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_at_drive = 16'h0;
    res_t       sb_q[$];

    multi_reaction_timer #(
        .N_PLAYERS   (2),
        .CNT_W       (4),
        .DELAY_MIN   (3),
        .DELAY_SPAN_W(2),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk    (clk),
        .clear  (clear),
        .tick   (tick),
        .start  (start),
        .stop   (stop),
        .led    (led),
        .state  (state),
        .times  (times),
        .valid  (valid),
        .foul   (foul),
        .winner (winner),
        .timeout(timeout)
    );

    initial forever #5 clk = ~clk;

    // Reference random source, stepping on the same edges as the design's.
    always @(posedge clk or posedge clear) begin
        if (clear) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop();
        res_t e;
        check_eq("sb_pending", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("done_times",   times,   e.times);
            check_eq("done_valid",   valid,   e.valid);
            check_eq("done_foul",    foul,    e.foul);
            check_eq("done_winner",  winner,  e.winner);
            check_eq("done_timeout", timeout, e.timeout);
            check_eq("done_led",     led,     1'b0);
        end
    endtask

    // One clock edge: drive after negedge, observe 1 ns after posedge.
    task automatic step(input logic [1:0] stp);
        @(negedge clk);
        tick          = (phase == 3);
        last_tick     = tick;
        phase         = (phase + 1) % 4;
        stop          = stp;
        start         = start_lvl;
        lfsr_at_drive = lfsr_m;
        @(posedge clk);
        #1;
        led_seen = led_seen | led;
        if (state == 2'd3 && prev_state != 2'd3) sb_pop();
        prev_state = state;
    endtask

    task automatic press(input logic [1:0] stp);
        step(stp);
        if (last_tick) go_ticks++;
    endtask

    task automatic go_wait(input int k);
        for (int s = 0; s < 100 && go_ticks < k; s++) press(2'b00);
    endtask

    task automatic arm();
        start_lvl = 1'b0;
        step(2'b00);
        start_lvl = 1'b1;
        step(2'b00);
        exp_delay = 3 + int'(lfsr_at_drive[1:0]);
        check_eq("arm_state", state, 2'd1);
        check_eq("arm_led", led, 1'b0);
        check_eq("arm_cleared", {times, valid, foul, winner, timeout}, 15'd0);
    endtask

    task automatic wait_go(input logic [1:0] early);
        int n = 0;
        start_lvl = 1'b0;
        go_ticks  = 0;
        for (int s = 0; s < 64 && n < exp_delay; s++) begin
            step(s == 0 ? early : 2'b00);
            if (last_tick) begin
                n++;
                if (n == exp_delay - 1) check_eq("armed_led", led, 1'b0);
            end
        end
        check_eq("go_led", led, 1'b1);
        check_eq("go_state", state, 2'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1;
        start = 1'b1;
        start_lvl = 1'b1;
        stop  = 2'b00;
        tick  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b0;

        // Start held through reset release must not arm.
        step(2'b00);
        step(2'b00);
        check_eq("rst_state",   state,   2'd0);
        check_eq("rst_led",     led,     1'b0);
        check_eq("rst_times",   times,   8'h00);
        check_eq("rst_valid",   valid,   2'b00);
        check_eq("rst_foul",    foul,    2'b00);
        check_eq("rst_winner",  winner,  2'b00);
        check_eq("rst_timeout", timeout, 1'b0);

        // Legal race: p1 at 5 ticks, p0 at 7 ticks.
        sb_q.push_back('{times: 8'h57, valid: 2'b11, foul: 2'b00, winner: 2'b10, timeout: 1'b0});
        arm();
        wait_go(2'b00);
        go_wait(5);
        press(2'b10);
        press(2'b00);
        check_eq("race_mid_valid", valid, 2'b10);
        go_wait(7);
        press(2'b01);
        check_eq("race_state", state, 2'd3);

        // Tie coinciding with the 4th GO tick captures the pre-increment value.
        sb_q.push_back('{times: 8'h33, valid: 2'b11, foul: 2'b00, winner: 2'b01, timeout: 1'b0});
        arm();
        wait_go(2'b00);
        go_wait(3);
        for (int s = 0; s < 8 && phase != 3; s++) press(2'b00);
        press(2'b11);
        check_eq("tie_state", state, 2'd3);

        // p0 fouls in ARMED, p1 legal after 2 ticks.
        sb_q.push_back('{times: 8'h20, valid: 2'b10, foul: 2'b01, winner: 2'b10, timeout: 1'b0});
        arm();
        wait_go(2'b01);
        check_eq("foul_armed", foul, 2'b01);
        go_wait(2);
        press(2'b10);
        check_eq("foul_state", state, 2'd3);

        // Both foul: round ends without GO.
        sb_q.push_back('{times: 8'h00, valid: 2'b00, foul: 2'b11, winner: 2'b00, timeout: 1'b0});
        arm();
        led_seen = 1'b0;
        start_lvl = 1'b0;
        step(2'b11);
        check_eq("allfoul_state", state, 2'd3);
        repeat (32) step(2'b00);
        check_eq("allfoul_led_never", led_seen, 1'b0);
        check_eq("allfoul_hold", state, 2'd3);

        // Nobody presses: timeout on the 15th GO tick.
        sb_q.push_back('{times: 8'h00, valid: 2'b00, foul: 2'b00, winner: 2'b00, timeout: 1'b1});
        arm();
        wait_go(2'b00);
        go_wait(14);
        check_eq("to_pre_state", state, 2'd2);
        go_wait(15);
        check_eq("to_state", state, 2'd3);

        // Timeout with p0 resolved after 4 ticks.
        sb_q.push_back('{times: 8'h04, valid: 2'b01, foul: 2'b00, winner: 2'b01, timeout: 1'b1});
        arm();
        wait_go(2'b00);
        go_wait(4);
        press(2'b01);
        go_wait(15);
        check_eq("to1_state", state, 2'd3);

        // Asynchronous abort mid-GO.
        arm();
        wait_go(2'b00);
        go_wait(2);
        press(2'b01);
        check_eq("abort_pre_valid", valid, 2'b01);
        #2 clear = 1'b1;
        #1;
        check_eq("abort_state", state, 2'd0);
        check_eq("abort_led",   led,   1'b0);
        check_eq("abort_res",   {times, valid, foul, winner, timeout}, 15'd0);
        @(negedge clk);
        clear = 1'b0;
        prev_state = 2'd0;

        // Fresh round after abort: wait restarts from the reseeded sequence.
        sb_q.push_back('{times: 8'h11, valid: 2'b11, foul: 2'b00, winner: 2'b01, timeout: 1'b0});
        arm();
        wait_go(2'b00);
        go_wait(1);
        press(2'b11);
        check_eq("post_abort_state", state, 2'd3);

        repeat (4) step(2'b00);
        check_eq("sb_left", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
